// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/div with architectural HI/LO and mfhi/mflo/mthi/mtlo.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu; otherwise those op codes act as NONE.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_res
);

    localparam logic [3:0] OP_NONE  = 4'd0,  OP_MULT  = 4'd1,  OP_MULTU = 4'd2,
                           OP_DIV   = 4'd3,  OP_DIVU  = 4'd4,  OP_MFHI  = 4'd5,
                           OP_MFLO  = 4'd6,  OP_MTHI  = 4'd7,  OP_MTLO  = 4'd8,
                           OP_MADD  = 4'd9,  OP_MADDU = 4'd10, OP_MSUB  = 4'd11,
                           OP_MSUBU = 4'd12;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_tmp, lo_tmp, hi_tmp_d, lo_tmp_d, hi_d, lo_d;
    logic [3:0]         op;
    logic               is_mul, is_div, is_acc;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u, res;
    logic [31:0]        q_s, r_s, q_u, r_u;

    assign op = en ? md_op : OP_NONE;

    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        is_acc = 1'b0;
`ifdef MDU_MADD_EN
        is_acc = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
        is_acc = 1'b0;
`endif
    end

    assign start  = (state_q == IDLE) && (is_mul || is_div || is_acc);
    assign md_res = (op == OP_MFHI) ? HI : (op == OP_MFLO) ? LO : 32'd0;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // The one signed-divide overflow case is pinned explicitly rather than trusting operator wrap.
    always_comb begin
        if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            q_s = 32'h8000_0000;
            r_s = 32'd0;
        end else begin
            q_s = $signed(A) / $signed(B);
            r_s = $signed(A) % $signed(B);
        end
        q_u = A / B;
        r_u = A % B;
    end

    // Divide by zero reloads the current HI/LO so write-back is a no-op.
    always_comb begin
        res = {HI, LO};
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   if (B != 32'd0) res = {r_s, q_s};
            OP_DIVU:  if (B != 32'd0) res = {r_u, q_u};
            OP_MADD:  res = {HI, LO} + prod_s;
            OP_MADDU: res = {HI, LO} + prod_u;
            OP_MSUB:  res = {HI, LO} - prod_s;
            OP_MSUBU: res = {HI, LO} - prod_u;
            default:  res = {HI, LO};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_tmp_d = hi_tmp;
        lo_tmp_d = lo_tmp;
        hi_d     = HI;
        lo_d     = LO;
        case (state_q)
            IDLE: begin
                if (start) begin
                    {hi_tmp_d, lo_tmp_d} = res;
                    cnt_d   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                    state_d = BUSY;
                end else if (op == OP_MTHI) begin
                    hi_d = A;
                end else if (op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    hi_d    = hi_tmp;
                    lo_d    = lo_tmp;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_tmp  <= '0;
            lo_tmp  <= '0;
            HI      <= '0;
            LO      <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_tmp  <= hi_tmp_d;
            lo_tmp  <= lo_tmp_d;
            HI      <= hi_d;
            LO      <= lo_d;
            busy    <= (state_d == BUSY);
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed, table-driven bench for e_mdu: arithmetic vectors plus hand-written busy/reset/ignore sequences.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                           OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7,
                           OP_MTLO = 4'd8, OP_MADDU = 4'd10, OP_MSUB = 4'd11;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [3:0]  md_op;
    logic [31:0] A, B;
    logic        start, busy;
    logic [31:0] HI, LO, md_res;

    int total = 0;
    int bad   = 0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .en(en), .md_op(md_op), .A(A), .B(B),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .md_res(md_res)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, hi, lo;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        en = 1'b1; md_op = OP_MTHI; A = h; tick();
        md_op = OP_MTLO; A = l; tick();
        en = 1'b0; md_op = OP_NONE;
    endtask

    // Issue at cycle T, expect busy for n cycles with HI/LO frozen, then the new values.
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] ohi, olo;
        ohi = HI; olo = LO;
        en = 1'b1; md_op = op; A = a; B = b; #1;
        check({nm, " start"}, 32'(start), 32'd1);
        tick();
        en = 1'b0; md_op = OP_NONE;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s busy c%0d", nm, i + 1), 32'(busy), 32'd1);
            check($sformatf("%s hi hold c%0d", nm, i + 1), HI, ohi);
            check($sformatf("%s lo hold c%0d", nm, i + 1), LO, olo);
            tick();
        end
        check({nm, " busy end"}, 32'(busy), 32'd0);
        check({nm, " hi"}, HI, ehi);
        check({nm, " lo"}, LO, elo);
    endtask

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    32'h0,    32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU,  32'd7,        32'd0,        32'h11,   32'h22,   32'h11,       32'h22};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,    32'h0,    32'h0,        32'h80000000};
        vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'h0,    32'h0,    32'd2,        32'd14};
        vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,    32'h0,    32'd1,        32'hFFFFFFFD};
        vecs[7] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,    32'h0,    32'h3FFFFFFF, 32'h00000001};
        vecs[8] = '{OP_DIV,   32'd5,        32'd0,        32'hAAAA, 32'hBBBB, 32'hAAAA,     32'hBBBB};

        reset = 1'b1; en = 1'b0; md_op = OP_NONE; A = '0; B = '0;
        tick(); tick();
        reset = 1'b0; #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst hi", HI, 32'd0);
        check("rst lo", LO, 32'd0);
        check("rst start", 32'(start), 32'd0);
        check("rst md_res", md_res, 32'd0);

        for (int i = 0; i < 9; i++) begin
            set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   (vecs[i].op == OP_DIV || vecs[i].op == OP_DIVU) ? DC : MC,
                   vecs[i].hi, vecs[i].lo);
            en = 1'b1; md_op = OP_MFHI; #1;
            check($sformatf("vec%0d mfhi", i), md_res, vecs[i].hi);
            md_op = OP_MFLO; #1;
            check($sformatf("vec%0d mflo", i), md_res, vecs[i].lo);
            en = 1'b0; md_op = OP_NONE;
        end

        // mthi then mfhi next cycle; mtlo with en low does nothing
        set_hilo(32'h0, 32'h55);
        en = 1'b1; md_op = OP_MTHI; A = 32'h12345678; #1;
        check("mthi start", 32'(start), 32'd0);
        tick();
        md_op = OP_MFHI; #1;
        check("mfhi after mthi", md_res, 32'h12345678);
        en = 1'b0; md_op = OP_MTLO; A = 32'h999; #1;
        check("en0 md_res", md_res, 32'd0);
        tick();
        check("mtlo en0 lo", LO, 32'h55);

        // reserved op code
        en = 1'b1; md_op = 4'd13; A = 32'd3; B = 32'd3; #1;
        check("op13 start", 32'(start), 32'd0);
        check("op13 md_res", md_res, 32'd0);
        tick();
        check("op13 busy", 32'(busy), 32'd0);
        en = 1'b0; md_op = OP_NONE;

        // mtlo during busy is ignored, mflo reads old LO
        set_hilo(32'h0, 32'h0);
        en = 1'b1; md_op = OP_MULT; A = 32'd3; B = 32'd4; tick();
        en = 1'b0; md_op = OP_NONE; tick();
        en = 1'b1; md_op = OP_MFLO; #1;
        check("busy mflo old", md_res, 32'd0);
        tick();
        md_op = OP_MTLO; A = 32'hDEAD; #1;
        check("busy mtlo start", 32'(start), 32'd0);
        tick();
        en = 1'b0; md_op = OP_NONE;
        check("busy mtlo lo", LO, 32'd0);
        check("busy c4", 32'(busy), 32'd1);
        tick();
        check("busy c5", 32'(busy), 32'd1);
        tick();
        check("ign busy end", 32'(busy), 32'd0);
        check("ign lo", LO, 32'd12);
        check("ign hi", HI, 32'd0);

        // reset at busy cycle 2 of a divide aborts it
        set_hilo(32'h5, 32'h6);
        en = 1'b1; md_op = OP_DIV; A = 32'd100; B = 32'd7; tick();
        en = 1'b0; md_op = OP_NONE; tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi", HI, 32'd0);
        check("abort lo", LO, 32'd0);
        repeat (DC + 2) tick();
        check("abort late hi", HI, 32'd0);
        check("abort late lo", LO, 32'd0);
        check("abort late busy", 32'(busy), 32'd0);

        // start coincident with reset: reset wins
        set_hilo(32'h5, 32'h6);
        reset = 1'b1; en = 1'b1; md_op = OP_MULT; A = 32'd2; B = 32'd3; tick();
        reset = 1'b0; en = 1'b0; md_op = OP_NONE;
        check("rst+start busy", 32'(busy), 32'd0);
        check("rst+start lo", LO, 32'd0);
        tick();
        check("rst+start busy2", 32'(busy), 32'd0);

        set_hilo(32'h0, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, MC, 32'h1, 32'h0);
        run_op("msub", OP_MSUB, 32'd1, 32'd1, MC, 32'h0, 32'hFFFFFFFF);
`else
        en = 1'b1; md_op = OP_MADDU; A = 32'd1; B = 32'd1; #1;
        check("maddu off start", 32'(start), 32'd0);
        tick();
        en = 1'b0; md_op = OP_NONE;
        check("maddu off busy", 32'(busy), 32'd0);
        repeat (MC + 1) tick();
        check("maddu off hi", HI, 32'h0);
        check("maddu off lo", LO, 32'hFFFFFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
